// File: rtl/axi_sram_slave.sv
// axi_sram_slave: single-port word SRAM behind a minimal AXI slave.
// Reads are INCR bursts of up to 16 beats. Writes are single-beat with byte strobes.
// The read and write engines run independently of each other.
// Build option AXI_SLV_DELAY_EN: inserts RD_DELAY wait cycles before the first read beat.
module axi_sram_slave #(
   parameter int unsigned ADDR_BITS = 16,
   parameter int unsigned RD_DELAY  = 3
) (
   input  logic        clk,
   input  logic        aresetn,
   // read address channel
   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   input  logic [7:0]  arlen,
   input  logic        arvalid,
   output logic        arready,
   // read data channel
   output logic [3:0]  rid,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready,
   // write address channel
   input  logic [3:0]  awid,
   input  logic [31:0] awaddr,
   input  logic        awvalid,
   output logic        awready,
   // write data channel
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wvalid,
   output logic        wready,
   // write response channel
   output logic [3:0]  bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam int unsigned DEPTH = 32'd1 << ADDR_BITS;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
`ifdef AXI_SLV_DELAY_EN
      R_WAIT = 2'd1,
`endif
      R_DATA = 2'd2
   } rstate_t;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } wstate_t;

   logic [31:0] mem [DEPTH];

   rstate_t              rstate;
   logic [ADDR_BITS-1:0] ridx;
   logic [3:0]           rlen;
   logic [3:0]           rbeat;
`ifdef AXI_SLV_DELAY_EN
   logic [3:0]           wait_cnt;
`endif

   wstate_t              wstate;
   logic [ADDR_BITS-1:0] widx;

   logic [ADDR_BITS-1:0] ar_idx_c;
   logic [ADDR_BITS-1:0] aw_idx_c;
   logic [ADDR_BITS-1:0] ridx_next_c;
   logic [3:0]           rbeat_next_c;
   logic                 unused_bits;

   assign ar_idx_c     = araddr[ADDR_BITS+1:2];
   assign aw_idx_c     = awaddr[ADDR_BITS+1:2];
   assign ridx_next_c  = ADDR_BITS'(ridx + 1'b1);
   assign rbeat_next_c = 4'(rbeat + 4'd1);

   // every access completes OKAY
   assign rresp = 2'b00;
   assign bresp = 2'b00;

   // address bits above the memory, byte-lane bits and the upper arlen nibble are don't-care
   assign unused_bits = ^{araddr[31:ADDR_BITS+2], araddr[1:0],
                          awaddr[31:ADDR_BITS+2], awaddr[1:0],
                          arlen[7:4], 4'(RD_DELAY)};

   // read engine: accept a burst, optionally wait, then stream beats with index wrap
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         rstate   <= R_IDLE;
         arready  <= 1'b1;
         rvalid   <= 1'b0;
         rlast    <= 1'b0;
         rdata    <= '0;
         rid      <= '0;
         ridx     <= '0;
         rlen     <= '0;
         rbeat    <= '0;
`ifdef AXI_SLV_DELAY_EN
         wait_cnt <= '0;
`endif
      end else begin
         case (rstate)
            R_IDLE: begin
               if (arvalid) begin
                  arready <= 1'b0;
                  rid     <= arid;
                  rlen    <= arlen[3:0];
                  rbeat   <= '0;
                  ridx    <= ar_idx_c;
`ifdef AXI_SLV_DELAY_EN
                  wait_cnt <= 4'(RD_DELAY - 1);
                  rstate   <= R_WAIT;
`else
                  rdata   <= mem[ar_idx_c];
                  rvalid  <= 1'b1;
                  rlast   <= (arlen[3:0] == 4'd0);
                  rstate  <= R_DATA;
`endif
               end
            end
`ifdef AXI_SLV_DELAY_EN
            R_WAIT: begin
               if (wait_cnt == 4'd0) begin
                  rdata  <= mem[ridx];
                  rvalid <= 1'b1;
                  rlast  <= (rlen == 4'd0);
                  rstate <= R_DATA;
               end else begin
                  wait_cnt <= 4'(wait_cnt - 4'd1);
               end
            end
`endif
            R_DATA: begin
               if (rready) begin
                  if (rlast) begin
                     rvalid  <= 1'b0;
                     rlast   <= 1'b0;
                     arready <= 1'b1;
                     rstate  <= R_IDLE;
                  end else begin
                     ridx  <= ridx_next_c;
                     rdata <= mem[ridx_next_c];
                     rbeat <= rbeat_next_c;
                     rlast <= (rbeat_next_c == rlen);
                  end
               end
            end
            default: begin
               rstate  <= R_IDLE;
               arready <= 1'b1;
               rvalid  <= 1'b0;
               rlast   <= 1'b0;
            end
         endcase
      end
   end

   // write engine: address, one data beat, then hold the response until taken
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         wstate  <= W_IDLE;
         awready <= 1'b1;
         wready  <= 1'b0;
         bvalid  <= 1'b0;
         bid     <= '0;
         widx    <= '0;
      end else begin
         case (wstate)
            W_IDLE: begin
               if (awvalid) begin
                  awready <= 1'b0;
                  wready  <= 1'b1;
                  bid     <= awid;
                  widx    <= aw_idx_c;
                  wstate  <= W_DATA;
               end
            end
            W_DATA: begin
               if (wvalid) begin
                  wready <= 1'b0;
                  bvalid <= 1'b1;
                  wstate <= W_RESP;
               end
            end
            W_RESP: begin
               if (bready) begin
                  bvalid  <= 1'b0;
                  awready <= 1'b1;
                  wstate  <= W_IDLE;
               end
            end
            default: begin
               wstate  <= W_IDLE;
               awready <= 1'b1;
               wready  <= 1'b0;
               bvalid  <= 1'b0;
            end
         endcase
      end
   end

   // byte-masked memory update on the write data handshake; contents survive reset
   always_ff @(posedge clk) begin
      if (aresetn && wready && wvalid) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
               mem[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Bench for axi_sram_slave: write/readback vector table, burst scoreboard, and
// hand-written sequences for wrap, stall, concurrency, same-cycle hazard and reset.
module tb_axi_sram_slave;

   localparam int unsigned RD_DELAY = 3;
`ifdef AXI_SLV_DELAY_EN
   localparam int LAT = RD_DELAY + 1;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        aresetn;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   always #5 clk = ~clk;

   axi_sram_slave #(.ADDR_BITS(16), .RD_DELAY(RD_DELAY)) dut (
      .clk(clk), .aresetn(aresetn),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   typedef struct {
      logic [31:0] data;
      logic [3:0]  id;
      logic        last;
   } beat_t;

   typedef struct {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp;
   } vec_t;

   beat_t       sb[$];
   logic [31:0] model [int];
   vec_t        vt [10];
   int          checks = 0;
   int          errors = 0;

   function automatic int widx(input logic [31:0] addr);
      return int'(addr[17:2]);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_model(input logic [3:0] id, input logic [31:0] addr, input int len);
      for (int i = 0; i <= len; i++) begin
         int w;
         w = (widx(addr) + i) % 65536;
         sb.push_back('{data: model[w], id: id, last: (i == len)});
      end
   endtask

   task automatic wait_rvalid(input string name);
      int n;
      n = 0;
      while (!rvalid && n < 64) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(rvalid), 32'd1);
   endtask

   task automatic do_write(input logic [3:0] id, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb);
      logic [31:0] old;
      int w;
      @(negedge clk);
      awid = id; awaddr = addr; awvalid = 1'b1;
      check("awready_idle", 32'(awready), 32'd1);
      @(negedge clk);
      awvalid = 1'b0;
      check("wready_t1", 32'(wready), 32'd1);
      check("bvalid_t1", 32'(bvalid), 32'd0);
      wdata = data; wstrb = strb; wvalid = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
      check("bvalid_t2", 32'(bvalid), 32'd1);
      check("bid", 32'(bid), 32'(id));
      check("bresp", 32'(bresp), 32'd0);
      check("wready_t2", 32'(wready), 32'd0);
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      check("bvalid_clr", 32'(bvalid), 32'd0);
      check("awready_back", 32'(awready), 32'd1);
      w = widx(addr);
      old = model.exists(w) ? model[w] : 32'h0;
      for (int b = 0; b < 4; b++)
         if (strb[b]) old[8*b +: 8] = data[8*b +: 8];
      model[w] = old;
   endtask

   // issue a burst and drain the scoreboard with the given per-cycle rready pattern
   task automatic read_run(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [15:0] pattern);
      int n;
      int p;
      @(negedge clk);
      arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
      check("arready_idle", 32'(arready), 32'd1);
      @(negedge clk);
      arvalid = 1'b0;
      n = 1;
      while (!rvalid && n < 64) begin
         @(negedge clk);
         n++;
      end
      check("rd_latency", 32'(n), 32'(LAT));
      p = 0;
      while (sb.size() > 0 && p < 200) begin
         rready = pattern[p % 16];
         p++;
         check("rvalid_burst", 32'(rvalid), 32'd1);
         check("rdata", rdata, sb[0].data);
         check("rid", 32'(rid), 32'(sb[0].id));
         check("rlast", 32'(rlast), 32'(sb[0].last));
         check("rresp", 32'(rresp), 32'd0);
         if (rready) void'(sb.pop_front());
         @(negedge clk);
      end
      rready = 1'b0;
      check("sb_drained", 32'(sb.size()), 32'd0);
      check("rvalid_end", 32'(rvalid), 32'd0);
      check("arready_end", 32'(arready), 32'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vt[0] = '{id: 4'h1, addr: 32'h0000_0010, data: 32'hDEAD_BEEF, strb: 4'b1111, exp: 32'hDEAD_BEEF};
      vt[1] = '{id: 4'h2, addr: 32'h0000_0020, data: 32'h1122_3344, strb: 4'b1111, exp: 32'h1122_3344};
      vt[2] = '{id: 4'h3, addr: 32'h0000_0020, data: 32'h0000_AA00, strb: 4'b0010, exp: 32'h1122_AA44};
      vt[3] = '{id: 4'h4, addr: 32'h0000_0020, data: 32'hFFFF_FFFF, strb: 4'b0000, exp: 32'h1122_AA44};
      vt[4] = '{id: 4'h5, addr: 32'h0000_0023, data: 32'h5500_0000, strb: 4'b1000, exp: 32'h5522_AA44};
      vt[5] = '{id: 4'h6, addr: 32'h0004_0010, data: 32'hCAFE_F00D, strb: 4'b1111, exp: 32'hCAFE_F00D};
      vt[6] = '{id: 4'h7, addr: 32'h0003_FFFC, data: 32'hA0A0_A0A0, strb: 4'b1111, exp: 32'hA0A0_A0A0};
      vt[7] = '{id: 4'h8, addr: 32'h0000_0000, data: 32'hB0B0_B0B0, strb: 4'b1111, exp: 32'hB0B0_B0B0};
      vt[8] = '{id: 4'hA, addr: 32'h0000_0004, data: 32'hC0C0_C0C0, strb: 4'b1111, exp: 32'hC0C0_C0C0};
      vt[9] = '{id: 4'hF, addr: 32'h0000_0008, data: 32'hD0D0_D0D0, strb: 4'b1111, exp: 32'hD0D0_D0D0};

      aresetn = 1'b0;
      arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
      awid = '0; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_arready", 32'(arready), 32'd1);
      check("rst_awready", 32'(awready), 32'd1);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_wready", 32'(wready), 32'd0);
      check("rst_bvalid", 32'(bvalid), 32'd0);
      check("rst_rlast", 32'(rlast), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_rid", 32'(rid), 32'd0);
      check("rst_bid", 32'(bid), 32'd0);
      aresetn = 1'b1;

      // write then single-beat readback for each table vector
      for (int i = 0; i < 10; i++) begin
         do_write(vt[i].id, vt[i].addr, vt[i].data, vt[i].strb);
         sb.push_back('{data: vt[i].exp, id: ~vt[i].id, last: 1'b1});
         read_run(~vt[i].id, vt[i].addr, 8'd0, 16'hFFFF);
      end

      // burst from the last word wraps to word 0, rready alternating 1010
      push_model(4'hC, 32'h0003_FFFC, 3);
      read_run(4'hC, 32'h0003_FFFC, 8'd3, 16'h5555);

      // upper arlen bits are ignored: only the low nibble sets the beat count
      push_model(4'h2, 32'h0000_0000, 2);
      read_run(4'h2, 32'h0000_0000, 8'hF2, 16'hFFFF);

      // read and write issued in the same cycle with different ids
      @(negedge clk);
      arid = 4'd5; araddr = 32'h20; arlen = 8'd0; arvalid = 1'b1;
      awid = 4'd9; awaddr = 32'h30; awvalid = 1'b1;
      sb.push_back('{data: 32'h5522_AA44, id: 4'd5, last: 1'b1});
      check("conc_arready", 32'(arready), 32'd1);
      check("conc_awready", 32'(awready), 32'd1);
      @(negedge clk);
      arvalid = 1'b0; awvalid = 1'b0;
      check("conc_wready", 32'(wready), 32'd1);
      wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
      check("conc_bvalid", 32'(bvalid), 32'd1);
      check("conc_bid", 32'(bid), 32'd9);
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      check("conc_bvalid_clr", 32'(bvalid), 32'd0);
      wait_rvalid("conc_rvalid");
      check("conc_rid", 32'(rid), 32'(sb[0].id));
      check("conc_rdata", rdata, sb[0].data);
      check("conc_rlast", 32'(rlast), 32'(sb[0].last));
      rready = 1'b1;
      void'(sb.pop_front());
      @(negedge clk);
      rready = 1'b0;
      check("conc_rvalid_end", 32'(rvalid), 32'd0);
      model[12] = 32'h1234_5678;
      push_model(4'h1, 32'h30, 0);
      read_run(4'h1, 32'h30, 8'd0, 16'hFFFF);

      // next read beat loaded on the same edge as a write to that word sees the old data
      do_write(4'h0, 32'h54, 32'h0101_0101, 4'hF);
      do_write(4'h0, 32'h50, 32'h0202_0202, 4'hF);
      @(negedge clk);
      arid = 4'h6; araddr = 32'h50; arlen = 8'd1; arvalid = 1'b1;
      awid = 4'h7; awaddr = 32'h54; awvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0; awvalid = 1'b0;
      wait_rvalid("haz_rvalid");
      check("haz_beat0", rdata, 32'h0202_0202);
      check("haz_wready", 32'(wready), 32'd1);
      rready = 1'b1;
      wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
      check("haz_beat1_old", rdata, 32'h0101_0101);
      check("haz_rlast", 32'(rlast), 32'd1);
      check("haz_bvalid", 32'(bvalid), 32'd1);
      bready = 1'b1;
      @(negedge clk);
      rready = 1'b0; bready = 1'b0;
      check("haz_rvalid_end", 32'(rvalid), 32'd0);
      model[21] = 32'hFFFF_FFFF;
      push_model(4'h6, 32'h54, 0);
      read_run(4'h6, 32'h54, 8'd0, 16'hFFFF);

      // reset asserted while beat 2 of an 8-beat burst is presented
      @(negedge clk);
      arid = 4'h3; araddr = 32'h0; arlen = 8'd7; arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      wait_rvalid("rstb_rvalid");
      for (int b = 0; b < 3; b++) begin
         check("rstb_rdata", rdata, model[b]);
         check("rstb_rlast", 32'(rlast), 32'd0);
         if (b < 2) begin
            rready = 1'b1;
            @(negedge clk);
         end else begin
            rready = 1'b0;
            aresetn = 1'b0;
            @(negedge clk);
         end
      end
      check("rstb_rvalid_off", 32'(rvalid), 32'd0);
      check("rstb_arready", 32'(arready), 32'd1);
      check("rstb_rlast_off", 32'(rlast), 32'd0);
      check("rstb_rdata_zero", rdata, 32'd0);
      check("rstb_rid_zero", 32'(rid), 32'd0);
      check("rstb_bid_zero", 32'(bid), 32'd0);
      aresetn = 1'b1;
      push_model(4'h4, 32'h0, 2);
      read_run(4'h4, 32'h0, 8'd2, 16'hFFFF);
      push_model(4'h5, 32'h10, 0);
      read_run(4'h5, 32'h10, 8'd0, 16'hFFFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 ADDR_BITS, 16, word-address width; memory holds 2^ADDR_BITS 32-bit words.
REQ-002 RD_DELAY, 3, extra read wait cycles (1..15); used only when AXI_SLV_DELAY_EN is defined.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 aresetn  in  1  reset; synchronous, active-low.
REQ-005 arid  in  4  read request id.
REQ-006 araddr  in  32  read byte address; bits [1:0] ignored.
REQ-007 arlen  in  8  beats-1; only [3:0] used, INCR burst.
REQ-008 arvalid  in  1  read address valid.
REQ-009 arready  out  1  read address accept.
REQ-010 rid  out  4  id echoed from the accepted arid.
REQ-011 rdata  out  32  read data.
REQ-012 rresp  out  2  always 2'b00 (OKAY).
REQ-013 rlast  out  1  final beat of burst.
REQ-014 rvalid  out  1  read data valid.
REQ-015 rready  in  1  master accepts read data.
REQ-016 awid  in  4  write request id.
REQ-017 awaddr  in  32  write byte address; bits [1:0] ignored.
REQ-018 awvalid  in  1  write address valid.
REQ-019 awready  out  1  write address accept.
REQ-020 wdata  in  32  write data.
REQ-021 wstrb  in  4  byte enables; bit n selects wdata[8n+7:8n].
REQ-022 wvalid  in  1  write data valid.
REQ-023 wready  out  1  write data accept.
REQ-024 bid  out  4  id echoed from the accepted awid.
REQ-025 bresp  out  2  always 2'b00.
REQ-026 bvalid  out  1  write response valid.
REQ-027 bready  in  1  master accepts response.

Function
REQ-028 Word index = addr[ADDR_BITS+1:2]; higher address bits are ignored (aliasing); all accesses return OKAY.
REQ-029 Read FSM: R_IDLE -> (arvalid&arready) -> R_WAIT (macro only) -> R_DATA -> (rvalid&rready&rlast) -> R_IDLE; arready=1 only in R_IDLE.
REQ-030 Without the macro, an AR handshake in cycle T gives rvalid=1 in T+1 with data from the captured address.
REQ-031 On each rvalid&rready with rlast=0: word index +1, wrapping modulo 2^ADDR_BITS; next beat is valid in the following cycle.
REQ-032 rdata, rid and rlast are held stable while rvalid=1 and rready=0; rlast=1 exactly on beat arlen[3:0].
REQ-033 Write FSM: W_IDLE (awready=1) -> AW handshake -> W_DATA (wready=1) -> W handshake -> W_RESP (bvalid=1) -> bready -> W_IDLE; single beat only.
REQ-034 The memory write occurs on the W handshake, byte-masked by wstrb; wstrb=0000 leaves the memory unchanged and still yields a response.
REQ-035 Minimum write timing: AW handshake in T, W handshake in T+1, bvalid in T+2.
REQ-036 Read and write FSMs run independently; a read beat loaded in the same cycle as a write to the same word returns the pre-write value.

Reset
REQ-037 While aresetn=0: both FSMs go idle, arready=awready=1, rvalid=wready=bvalid=rlast=0, rdata/rid/bid=0; in-flight bursts are dropped; memory contents are retained.

Configuration
REQ-038 AXI_SLV_DELAY_EN defined: after an AR handshake the FSM stays in R_WAIT for RD_DELAY cycles before the first beat (first rvalid at T+1+RD_DELAY); later beats have no delay.
REQ-039 AXI_SLV_DELAY_EN undefined: R_WAIT and its counter are absent; timing follows REQ-030.

Verification
REQ-040 Write awaddr=0x10, wdata=0xDEADBEEF, wstrb=1111, then read araddr=0x10, arlen=0 -> rdata=0xDEADBEEF, rlast=1, rresp=0, bvalid at T+2.
REQ-041 Write wstrb=0010, wdata=0x0000AA00 over word 0x11223344 -> readback 0x1122AA44.
REQ-042 Burst read arlen=3 at the last word with rready toggled 1010 -> four beats with the index wrapping to word 0, data stable while stalled, rlast only on the fourth beat.
REQ-043 arid=5, awid=9 issued in the same cycle -> rid=5, bid=9; both channels complete independently.
REQ-044 aresetn pulled low during beat 2 of an arlen=7 burst -> rvalid=0 next cycle, arready=1, prior memory data still readable.
REQ-045 AXI_SLV_DELAY_EN with RD_DELAY=3, AR handshake at cycle 10 -> first rvalid at cycle 14.
